// File: rtl/multicycle_cu.sv
// Multi-cycle MIPS control unit. A Moore FSM steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the shared-memory datapath's muxes and
// write enables. Memory accesses wait on mem_ready and fault once TIMEOUT cycles
// pass without it. Illegal opcodes also fault. The FAULT state is absorbing
// until reset.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   op, func          IR fields, sampled only in DECODE
//   zero              ALU zero flag, used only in BRANCH
//   mem_ready         memory access completes this cycle
//   ir_write .. pc_to_reg, alu_src_a/b, reg_dst, pc_src, alu_control
//                     datapath enables and selects
//   retire            1-cycle pulse when an instruction completes
//   retired_cnt       count of retired instructions, wraps to 0
//   fault             sticky fault flag
//   fault_code        01 illegal instruction, 10 memory timeout
module multicycle_cu #(
  parameter int unsigned ALUCTRL_W = 5,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned TO_W      = 4,
  parameter int unsigned RET_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           op,
  input  logic [5:0]           func,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 extend,
  output logic                 pc_to_reg,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           reg_dst,
  output logic [1:0]           pc_src,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 retire,
  output logic [RET_W-1:0]     retired_cnt,
  output logic                 fault,
  output logic [1:0]           fault_code
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StExecR, StWbR, StExecI, StWbI, StMemAddr,
    StMemRd, StWbMem, StMemWr, StBranch, StJump, StJr, StFault
  } state_e;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpJal  = 6'b000011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpSlti = 6'b001010;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] FnJr   = 6'b001000;

  localparam logic [4:0] AluAdd  = 5'b00000;
  localparam logic [4:0] AluBeq  = 5'b01101;
  localparam logic [4:0] AluBne  = 5'b01110;
  localparam logic [4:0] AluNone = 5'b11111;

  localparam logic [1:0] FcIllegal = 2'b01;
  localparam logic [1:0] FcTimeout = 2'b10;

  // ALU code for an R-type ALU/shift func; AluNone marks "not an R-ALU op".
  function automatic logic [4:0] r_alu(input logic [5:0] f);
    case (f)
      6'b100000: r_alu = 5'b00000;
      6'b100001: r_alu = 5'b00001;
      6'b100010: r_alu = 5'b00010;
      6'b100011: r_alu = 5'b00011;
      6'b100100: r_alu = 5'b00100;
      6'b100101: r_alu = 5'b00101;
      6'b100110: r_alu = 5'b00110;
      6'b100111: r_alu = 5'b00111;
      6'b101010: r_alu = 5'b01000;
      6'b101011: r_alu = 5'b01001;
      6'b000000, 6'b000100: r_alu = 5'b01010;
      6'b000010, 6'b000110: r_alu = 5'b01011;
      6'b000011, 6'b000111: r_alu = 5'b01100;
      default:   r_alu = AluNone;
    endcase
  endfunction

  // ALU code for an immediate ALU opcode; AluNone marks "not an I-ALU op".
  function automatic logic [4:0] i_alu(input logic [5:0] o);
    case (o)
      6'b001000: i_alu = 5'b00000;
      6'b001001: i_alu = 5'b00001;
      6'b001010: i_alu = 5'b01111;
      6'b001011: i_alu = 5'b01001;
      6'b001100: i_alu = 5'b00100;
      6'b001101: i_alu = 5'b00101;
      6'b001110: i_alu = 5'b00110;
      6'b001111: i_alu = 5'b10000;
      default:   i_alu = AluNone;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d, func_q, func_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic [RET_W-1:0] ret_q;
  logic [1:0]       fcode_q, fcode_d;
  logic [4:0]       alu;
  logic             waiting;
  logic             is_shamt;

  // Constant-shamt shifts take operand A from the shamt field, not rs.
  assign is_shamt = (func_q == 6'b000000) || (func_q == 6'b000010) || (func_q == 6'b000011);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    func_d      = func_q;
    cnt_d       = '0;
    fcode_d     = fcode_q;
    waiting     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    extend      = 1'b0;
    pc_to_reg   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    reg_dst     = 2'b00;
    pc_src      = 2'b00;
    retire      = 1'b0;
    alu         = AluNone;
    case (state_q)
      StFetch: begin
        waiting   = 1'b1;
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        alu       = AluAdd;
        pc_write  = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        op_d      = op;
        func_d    = func;
        alu_src_b = 2'b11;
        alu       = AluAdd;
        if (op == OpR) begin
          if (func == FnJr) begin
            state_d = StJr;
          end else if (r_alu(func) != AluNone) begin
            state_d = StExecR;
          end else begin
            state_d = StFault;
            fcode_d = FcIllegal;
          end
        end else if (i_alu(op) != AluNone) begin
          state_d = StExecI;
        end else begin
          case (op)
            OpLw, OpSw:   state_d = StMemAddr;
            OpBeq, OpBne: state_d = StBranch;
            OpJ, OpJal:   state_d = StJump;
            default: begin
              state_d = StFault;
              fcode_d = FcIllegal;
            end
          endcase
        end
      end
      StExecR: begin
        alu       = r_alu(func_q);
        alu_src_a = is_shamt ? 2'b10 : 2'b01;
        state_d   = StWbR;
      end
      StWbR: begin
        reg_dst   = 2'b01;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StExecI: begin
        alu       = i_alu(op_q);
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        extend    = (op_q == OpAddi) || (op_q == OpSlti);
        state_d   = StWbI;
      end
      StWbI: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StMemAddr: begin
        alu       = AluAdd;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        extend    = 1'b1;
        state_d   = (op_q == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        waiting  = 1'b1;
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = StWbMem;
      end
      StWbMem: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        waiting   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ready;
        if (mem_ready) state_d = StFetch;
      end
      StBranch: begin
        // The ALU raises zero when the branch condition holds for both beq and bne.
        alu       = (op_q == OpBne) ? AluBne : AluBeq;
        alu_src_a = 2'b01;
        extend    = 1'b1;
        pc_src    = 2'b01;
        pc_write  = zero;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StJump: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
        if (op_q == OpJal) begin
          reg_write = 1'b1;
          pc_to_reg = 1'b1;
          reg_dst   = 2'b10;
        end
        state_d = StFetch;
      end
      StJr: begin
        pc_src   = 2'b11;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StFault: ;
      default: state_d = StFetch;
    endcase
    // A not-ready cycle that would bring the wait count to TIMEOUT faults instead.
    if (waiting && !mem_ready) begin
      if (cnt_q == TO_W'(TIMEOUT - 1)) begin
        state_d = StFault;
        fcode_d = FcTimeout;
      end else begin
        cnt_d = cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      op_q    <= '0;
      func_q  <= '0;
      cnt_q   <= '0;
      ret_q   <= '0;
      fcode_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      func_q  <= func_d;
      cnt_q   <= cnt_d;
      fcode_q <= fcode_d;
      if (retire) ret_q <= ret_q + RET_W'(1);
    end
  end

  assign alu_control = ALUCTRL_W'(alu);
  assign retired_cnt = ret_q;
  assign fault       = (state_q == StFault);
  assign fault_code  = fcode_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Self-checking bench for multicycle_cu. Each instruction is expanded by a
// behavioural model into its expected per-cycle output records; one compare
// process checks the DUT against the current record on every falling edge.
module tb_multicycle_cu;

  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic       ir_write, pc_write, iord, mem_read, mem_write;
    logic       reg_write, mem_to_reg, extend, pc_to_reg;
    logic [1:0] alu_src_a, alu_src_b, reg_dst, pc_src;
    logic [4:0] alu;
    logic       retire, fault;
    logic [1:0] fault_code;
  } out_t;

  typedef enum int {KR, KJr, KI, KLw, KSw, KBr, KJ, KJal, KBad} kind_e;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0, func = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       ir_write, pc_write, iord, mem_read, mem_write, reg_write, mem_to_reg;
  logic       extend, pc_to_reg, retire, fault;
  logic [1:0] alu_src_a, alu_src_b, reg_dst, pc_src, fault_code;
  logic [4:0] alu_control;
  logic [3:0] retired_cnt;

  multicycle_cu #(
    .ALUCTRL_W(5),
    .TIMEOUT  (TIMEOUT),
    .TO_W     (4),
    .RET_W    (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .func       (func),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .extend     (extend),
    .pc_to_reg  (pc_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .reg_dst    (reg_dst),
    .pc_src     (pc_src),
    .alu_control(alu_control),
    .retire     (retire),
    .retired_cnt(retired_cnt),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  // Instruction tables: encodings and their ALU codes.
  logic [5:0] r_fn [16] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                            6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000100,
                            6'b000010, 6'b000110, 6'b000011, 6'b000111};
  logic [4:0] r_cd [16] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                            5'd10, 5'd10, 5'd11, 5'd11, 5'd12, 5'd12};
  logic [5:0] i_op [8]  = '{6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100, 6'b001101,
                            6'b001110, 6'b001111};
  logic [4:0] i_cd [8]  = '{5'd0, 5'd1, 5'd15, 5'd9, 5'd4, 5'd5, 5'd6, 5'd16};
  logic [5:0] o_op [6]  = '{6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b000011};

  // Expected state shared with the compare process (written only by the stimulus).
  out_t       exp_o;
  logic       exp_valid = 1'b0;
  logic [3:0] exp_cnt = '0;
  logic [1:0] fcode = '0;
  string      tag = "none";
  string      pin_nm [64];
  int         pin_act [64];
  int         pin_exp [64];
  int         pin_wr = 0;
  int         start_cyc = 0;

  // Owned by the compare process.
  int   checks = 0, errors = 0;
  int   cyc_n = 0, ret_cyc = 0, pin_rd = 0;
  out_t act;

  initial begin
    forever begin
      @(negedge clk);
      cyc_n = cyc_n + 1;
      if (retire === 1'b1) ret_cyc = cyc_n;
      if (exp_valid) begin
        act = {ir_write, pc_write, iord, mem_read, mem_write, reg_write, mem_to_reg, extend,
               pc_to_reg, alu_src_a, alu_src_b, reg_dst, pc_src, alu_control, retire, fault,
               fault_code};
        checks = checks + 1;
        if (act !== exp_o) begin
          errors = errors + 1;
          $display("FAIL %s outputs @%0t: got %h want %h", tag, $time, act, exp_o);
        end
        checks = checks + 1;
        if (retired_cnt !== exp_cnt) begin
          errors = errors + 1;
          $display("FAIL %s retired_cnt @%0t: got %0d want %0d", tag, $time, retired_cnt,
                   exp_cnt);
        end
      end
      while (pin_rd != pin_wr) begin
        checks = checks + 1;
        if (pin_act[pin_rd % 64] != pin_exp[pin_rd % 64]) begin
          errors = errors + 1;
          $display("FAIL %s: got %0d want %0d", pin_nm[pin_rd % 64], pin_act[pin_rd % 64],
                   pin_exp[pin_rd % 64]);
        end
        pin_rd = pin_rd + 1;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [5:0] rnd6();
    return 6'($urandom);
  endfunction

  function automatic logic rnd1();
    return 1'($urandom);
  endfunction

  function automatic out_t base();
    out_t o;
    o = '0;
    o.alu = 5'b11111;
    o.fault_code = fcode;
    return o;
  endfunction

  function automatic kind_e classify(input logic [5:0] o, input logic [5:0] f,
                                     output logic [4:0] code);
    code = 5'b11111;
    if (o == 6'b000000) begin
      if (f == 6'b001000) return KJr;
      for (int i = 0; i < 16; i++) if (r_fn[i] == f) begin code = r_cd[i]; return KR; end
      return KBad;
    end
    for (int i = 0; i < 8; i++) if (i_op[i] == o) begin code = i_cd[i]; return KI; end
    case (o)
      6'b100011: return KLw;
      6'b101011: return KSw;
      6'b000100: begin code = 5'b01101; return KBr; end
      6'b000101: begin code = 5'b01110; return KBr; end
      6'b000010: return KJ;
      6'b000011: return KJal;
      default:   return KBad;
    endcase
  endfunction

  // Post a literal expectation; the compare process evaluates it at the next falling edge.
  task automatic pin(input string nm, input int a, input int e);
    pin_nm[pin_wr % 64]  = nm;
    pin_act[pin_wr % 64] = a;
    pin_exp[pin_wr % 64] = e;
    pin_wr = pin_wr + 1;
  endtask

  // One clock cycle: drive inputs, publish expected outputs, advance past the edge.
  task automatic step(input out_t e, input logic rdy, input logic [5:0] o, input logic [5:0] f,
                      input logic z);
    mem_ready = rdy;
    op        = o;
    func      = f;
    zero      = z;
    exp_o     = e;
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
    if (e.retire) exp_cnt = exp_cnt + 4'd1;
  endtask

  task automatic step_any(input out_t e);
    step(e, rnd1(), rnd6(), rnd6(), rnd1());
  endtask

  // A memory access tolerates at most TIMEOUT-1 not-ready cycles.
  task automatic access(input out_t o_wait, input out_t o_done, input int waits, output bit ok);
    int n;
    n = (waits >= TIMEOUT) ? TIMEOUT : waits;
    for (int k = 0; k < n; k++) step(o_wait, 1'b0, rnd6(), rnd6(), rnd1());
    if (waits >= TIMEOUT) begin
      fcode = 2'b10;
      ok = 1'b0;
    end else begin
      step(o_done, 1'b1, rnd6(), rnd6(), rnd1());
      ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    out_t o;
    tag = "reset";
    rst_n = 1'b0;
    fcode = 2'b00;
    exp_cnt = '0;
    o = base();
    o.mem_read = 1'b1;
    o.ir_write = 1'b1;
    o.alu_src_b = 2'b01;
    o.alu = 5'b00000;
    step(o, 1'b0, rnd6(), rnd6(), rnd1());
    rst_n = 1'b1;
  endtask

  task automatic fault_tail();
    out_t o;
    tag = "fault";
    o = base();
    o.fault = 1'b1;
    for (int k = 0; k < 3; k++) step_any(o);
    pin("fault_code_held", int'(fault_code), int'(fcode));
    do_reset();
  endtask

  task automatic reset_mid_memwr();
    mem_ready = 1'b0;
    #1;
    pin("mem_write_before_reset", int'(mem_write), 1);
    rst_n = 1'b0;
    #1;
    pin("mem_write_in_reset", int'(mem_write), 0);
    pin("retired_cnt_in_reset", int'(retired_cnt), 0);
    do_reset();
  endtask

  task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn, input logic z,
                           input int wf, input int wm, input bit abort_wr);
    out_t o, od;
    logic [4:0] code;
    kind_e k;
    bit ok;
    k = classify(iop, ifn, code);
    start_cyc = cyc_n;
    tag = "fetch";
    o = base();
    o.mem_read = 1'b1;
    o.ir_write = 1'b1;
    o.alu_src_b = 2'b01;
    o.alu = 5'b00000;
    od = o;
    od.pc_write = 1'b1;
    access(o, od, wf, ok);
    if (!ok) begin
      fault_tail();
      return;
    end
    tag = "decode";
    o = base();
    o.alu_src_b = 2'b11;
    o.alu = 5'b00000;
    step(o, rnd1(), iop, ifn, rnd1());
    o = base();
    case (k)
      KR: begin
        tag = "exec_r";
        o.alu = code;
        o.alu_src_a = (ifn inside {6'b000000, 6'b000010, 6'b000011}) ? 2'b10 : 2'b01;
        step_any(o);
        tag = "wb_r";
        o = base();
        o.reg_dst = 2'b01;
        o.reg_write = 1'b1;
        o.retire = 1'b1;
        step_any(o);
      end
      KI: begin
        tag = "exec_i";
        o.alu = code;
        o.alu_src_a = 2'b01;
        o.alu_src_b = 2'b10;
        o.extend = (iop == 6'b001000) || (iop == 6'b001010);
        step_any(o);
        tag = "wb_i";
        o = base();
        o.reg_write = 1'b1;
        o.retire = 1'b1;
        step_any(o);
      end
      KLw, KSw: begin
        tag = "mem_addr";
        o.alu = 5'b00000;
        o.alu_src_a = 2'b01;
        o.alu_src_b = 2'b10;
        o.extend = 1'b1;
        step_any(o);
        o = base();
        o.iord = 1'b1;
        if (k == KLw) begin
          tag = "mem_rd";
          o.mem_read = 1'b1;
          access(o, o, wm, ok);
          if (!ok) begin
            fault_tail();
            return;
          end
          tag = "wb_mem";
          o = base();
          o.mem_to_reg = 1'b1;
          o.reg_write = 1'b1;
          o.retire = 1'b1;
          step_any(o);
        end else begin
          tag = "mem_wr";
          o.mem_write = 1'b1;
          if (abort_wr) begin
            reset_mid_memwr();
            return;
          end
          od = o;
          od.retire = 1'b1;
          access(o, od, wm, ok);
          if (!ok) fault_tail();
        end
      end
      KBr: begin
        tag = "branch";
        o.alu = code;
        o.alu_src_a = 2'b01;
        o.extend = 1'b1;
        o.pc_src = 2'b01;
        o.pc_write = z;
        o.retire = 1'b1;
        step(o, rnd1(), rnd6(), rnd6(), z);
      end
      KJ, KJal: begin
        tag = "jump";
        o.pc_src = 2'b10;
        o.pc_write = 1'b1;
        o.retire = 1'b1;
        if (k == KJal) begin
          o.reg_write = 1'b1;
          o.pc_to_reg = 1'b1;
          o.reg_dst = 2'b10;
        end
        step_any(o);
      end
      KJr: begin
        tag = "jr";
        o.pc_src = 2'b11;
        o.pc_write = 1'b1;
        o.retire = 1'b1;
        step_any(o);
      end
      default: begin
        fcode = 2'b01;
        fault_tail();
      end
    endcase
  endtask

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(0, 31));
    if (r < 24) return r % 4;
    if (r < 28) return TIMEOUT - 1;
    if (r < 30) return int'($urandom_range(4, 13));
    return TIMEOUT;
  endfunction

  initial begin
    logic [5:0] ro, rf;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // add with no waits: retires on cycle 4, counter reaches 1.
    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b0);
    pin("add_latency", ret_cyc - start_cyc, 4);
    pin("add_retired_cnt", int'(retired_cnt), 1);
    // lw with 3 not-ready cycles in MEM_RD: 8 cycles.
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 3, 1'b0);
    pin("lw_latency", ret_cyc - start_cyc, 8);
    run_instr(6'b000100, rnd6(), 1'b1, 0, 0, 1'b0);
    pin("beq_latency", ret_cyc - start_cyc, 3);
    run_instr(6'b000100, rnd6(), 1'b0, 0, 0, 1'b0);
    run_instr(6'b000101, rnd6(), 1'b1, 0, 0, 1'b0);
    run_instr(6'b000101, rnd6(), 1'b0, 1, 0, 1'b0);
    run_instr(6'b000011, rnd6(), 1'b0, 0, 0, 1'b0);
    pin("jal_latency", ret_cyc - start_cyc, 3);
    run_instr(6'b101011, rnd6(), 1'b0, 0, 0, 1'b0);
    pin("sw_latency", ret_cyc - start_cyc, 4);
    run_instr(6'b000000, 6'b001000, 1'b0, 0, 0, 1'b0);
    run_instr(6'b000000, 6'b000011, 1'b0, 0, 0, 1'b0);
    run_instr(6'b001111, rnd6(), 1'b0, 0, 0, 1'b0);
    // Ready on the 15th fetch cycle still proceeds.
    run_instr(6'b000010, rnd6(), 1'b0, TIMEOUT - 1, 0, 1'b0);
    pin("ready_on_last_cycle_latency", ret_cyc - start_cyc, 3 + TIMEOUT - 1);
    pin("ready_on_last_cycle_no_fault", int'(fault), 0);
    // Illegal opcode.
    run_instr(6'b111111, rnd6(), 1'b0, 0, 0, 1'b0);
    // Fetch timeout, then a store timeout.
    run_instr(6'b000010, rnd6(), 1'b0, TIMEOUT, 0, 1'b0);
    run_instr(6'b101011, rnd6(), 1'b0, 0, TIMEOUT, 1'b0);
    // Counter wrap after 16 retires from reset.
    for (int i = 0; i < 16; i++) run_instr(6'b000010, rnd6(), 1'b0, 0, 0, 1'b0);
    pin("retired_cnt_wrapped", int'(retired_cnt), 0);
    run_instr(6'b000010, rnd6(), 1'b0, 0, 0, 1'b0);
    pin("retired_cnt_after_wrap", int'(retired_cnt), 1);
    // Reset asserted in the middle of a store.
    run_instr(6'b101011, rnd6(), 1'b0, 0, 0, 1'b1);

    for (int n = 0; n < 250; n++) begin
      int pick;
      pick = int'($urandom_range(0, 39));
      if (pick == 0) begin
        ro = rnd1() ? 6'b111111 : 6'b100000;
        rf = rnd6();
      end else if (pick == 1) begin
        ro = 6'b000000;
        rf = rnd1() ? 6'b000001 : 6'b011111;
      end else if (pick < 20) begin
        ro = 6'b000000;
        rf = ($urandom_range(0, 16) == 16) ? 6'b001000 : r_fn[$urandom_range(0, 15)];
      end else if (pick < 30) begin
        ro = i_op[$urandom_range(0, 7)];
        rf = rnd6();
      end else begin
        ro = o_op[$urandom_range(0, 5)];
        rf = rnd6();
      end
      run_instr(ro, rf, rnd1(), rand_wait(), rand_wait(), 1'b0);
    end

    exp_valid = 1'b0;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
